// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// Holds funct3 encodings, FSM states and the latched request bundle.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } lsu_state_e;

  typedef struct packed {
    logic        load;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        mis;
    logic        ill;
  } lsu_req_t;

  // Neither or both of load/store set is treated as illegal.
  function automatic logic f3_illegal(
    input logic       ld,
    input logic       st,
    input logic [2:0] f3
  );
    if (ld == st) return 1'b1;
    if (ld) return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    return f3 > F3_W;
  endfunction

  function automatic logic f3_misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    return ((f3[1:0] == 2'b01) && a[0]) ||
           ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication and load
// lane select with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_uns;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_uns  = i_funct3[2];

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = '0;
    o_ldata = '0;
    unique case (1'b1)
      (i_funct3[1:0] == 2'b00): begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_sdata[7:0]}};
        o_ldata = w_uns ? {24'b0, w_byte}
                        : {{24{w_byte[7]}}, w_byte};
      end
      (i_funct3[1:0] == 2'b01): begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_sdata[15:0]}};
        o_ldata = w_uns ? {16'b0, w_half}
                        : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_sdata;
        o_ldata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: latches one EX op, runs it against a
// handshaked data memory and returns the extended load result.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_addr,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic [4:0]  resp_rd,
  output logic        misaligned,
  output logic        illegal,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       r_state;
  lsu_state_e       w_next;
  lsu_req_t         r_req;
  logic [CNT_W-1:0] r_cnt;
  logic             r_berr;
  logic [31:0]      r_ldata;

  logic        w_accept;
  logic        w_ill;
  logic        w_mis;
  logic        w_to;
  logic        w_in_req;
  logic        w_ok;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_ill    = f3_illegal(is_load, is_store, funct3);
  assign w_mis    = !w_ill && f3_misaligned(funct3, addr[1:0]);

  lsu_align u_align (
    .i_funct3  (r_req.f3),
    .i_addr_lo (r_req.addr[1:0]),
    .i_sdata   (r_req.wdata),
    .i_rdata   (dmem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_ldata   (w_ldata)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_to   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid)
          w_next = (w_ill || w_mis) ? S_RESP : S_REQ;
      end
      S_REQ: begin
        if (dmem_gnt) begin
          w_next = r_req.load ? S_WAIT : S_RESP;
        end else if (r_cnt == TO_LAST) begin
          w_to   = 1'b1;
          w_next = S_RESP;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          w_next = S_RESP;
        end else if (r_cnt == TO_LAST) begin
          w_to   = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req   <= '0;
      r_cnt   <= '0;
      r_berr  <= 1'b0;
      r_ldata <= '0;
    end else if (w_accept) begin
      r_req   <= '{load:  is_load,
                   f3:    funct3,
                   addr:  addr,
                   wdata: store_data,
                   rd:    rd_addr,
                   mis:   w_mis,
                   ill:   w_ill};
      r_cnt   <= '0;
      r_berr  <= 1'b0;
      r_ldata <= '0;
    end else if (w_to) begin
      r_berr <= 1'b1;
    end else if (r_state == S_REQ) begin
      r_cnt <= dmem_gnt ? '0 : r_cnt + 1'b1;
    end else if (r_state == S_WAIT) begin
      if (dmem_rvalid) r_ldata <= w_ldata;
      else             r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign w_in_req = (r_state == S_REQ);
  assign w_ok     = resp_valid && r_req.load &&
                    !r_req.mis && !r_req.ill && !r_berr;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign load_data  = w_ok ? r_ldata : '0;
  assign resp_rd    = w_ok ? r_req.rd : '0;
  assign misaligned = resp_valid && r_req.mis;
  assign illegal    = resp_valid && r_req.ill;
  assign bus_err    = resp_valid && r_berr;

  // Bus outputs are forced to zero outside REQ so they stay quiet.
  assign dmem_req   = w_in_req;
  assign dmem_we    = w_in_req && !r_req.load;
  assign dmem_addr  = w_in_req ? {r_req.addr[31:2], 2'b00} : '0;
  assign dmem_be    = w_in_req ? w_be : 4'b0000;
  assign dmem_wdata = (w_in_req && !r_req.load) ? w_wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-level reference
// model feeds expected responses and bus transactions into queues.
module tb_load_store_unit;

  localparam int TIMEOUT = 255;

  typedef struct {
    logic [31:0] ld;
    logic [4:0]  rd;
    bit          mis;
    bit          ill;
    bit          berr;
    bit          chk_mis;
    int          lat;
  } exp_t;

  typedef struct {
    bit          load;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          g;
    int          r;
    logic [31:0] rdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;
  logic        resp_valid;
  logic [31:0] load_data;
  logic [4:0]  resp_rd;
  logic        misaligned;
  logic        illegal;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  exp_t expq[$];
  bus_t busq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_resp = -10;
  bit   exp_b2b = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .is_load     (is_load),
    .is_store    (is_store),
    .funct3      (funct3),
    .addr        (addr),
    .store_data  (store_data),
    .rd_addr     (rd_addr),
    .resp_valid  (resp_valid),
    .load_data   (load_data),
    .resp_rd     (resp_rd),
    .misaligned  (misaligned),
    .illegal     (illegal),
    .bus_err     (bus_err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference: bytes of the word, widths 1/2/4, plain arithmetic.
  task automatic model(
    input bit ld, input bit st, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
    input int g, input int r, input logic [31:0] rdat,
    output exp_t e, output bus_t b, output bit acc
  );
    int sz, off, bem;
    logic [31:0] v, mask;
    e.ld = 0; e.rd = 0; e.mis = 0; e.ill = 0; e.berr = 0; e.lat = 0;
    b.load = ld; b.addr = 0; b.be = 0; b.wdata = 0;
    b.g = g; b.r = r; b.rdata = rdat;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(a % 4);
    e.ill = (ld && st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7))
            || (st && f3 > 2);
    e.chk_mis = !e.ill;
    e.mis = !e.ill && ((a % sz) != 0);
    acc = !e.ill && !e.mis;
    if (!acc) begin
      e.lat = 1;
      return;
    end
    b.addr = a & ~32'h3;
    bem = ((1 << sz) - 1) << off;
    b.be = bem[3:0];
    for (int i = 0; i < 4; i++)
      b.wdata[8*i +: 8] = sd[8*(i % sz) +: 8];
    if (g >= TIMEOUT) begin
      e.berr = 1; e.lat = TIMEOUT + 1;
    end else if (!ld) begin
      e.lat = g + 2;
    end else if (r == 0) begin
      e.berr = 1; e.lat = g + TIMEOUT + 2;
    end else begin
      e.lat = g + r + 2;
      v = rdat >> (8 * off);
      if (sz < 4) begin
        mask = (32'h1 << (8 * sz)) - 1;
        v = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
      end
      e.ld = v;
      e.rd = rd;
    end
  endtask

  task automatic issue(
    input bit ld, input bit st, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
    input int g, input int r, input logic [31:0] rdat,
    input bit hold, input bit b2b
  );
    exp_t e; bus_t b; bit acc; int n;
    model(ld, st, f3, a, sd, rd, g, r, rdat, e, b, acc);
    expq.push_back(e);
    if (acc) busq.push_back(b);
    @(negedge clk);
    exp_b2b    = b2b;
    req_valid  = 1'b1;
    is_load    = ld;
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    rd_addr    = rd;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    exp_b2b = 0;
    if (!hold) begin
      req_valid  = 1'b0;
      addr       = $urandom;
      store_data = $urandom;
      funct3     = 3'($urandom);
      rd_addr    = 5'($urandom);
    end
  endtask

  // Monitor: samples settled outputs shortly after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (resp_valid) begin
        if (expq.size() == 0) begin
          chk("resp_unexpected", {31'b0, resp_valid}, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("load_data", load_data, e.ld);
          chk("resp_rd", {27'b0, resp_rd}, {27'b0, e.rd});
          chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
          chk("bus_err", {31'b0, bus_err}, {31'b0, e.berr});
          if (e.chk_mis)
            chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
          chk("latency", cyc - acc_cyc, e.lat);
        end
        last_resp = cyc;
      end else begin
        chk("idle_flags", {26'b0, misaligned, illegal, bus_err, resp_rd},
            32'd0);
        chk("idle_ldata", load_data, 32'd0);
      end
      if (rst && req_valid && req_ready) begin
        acc_cyc = cyc;
        if (exp_b2b) chk("b2b_accept", cyc, last_resp + 1);
      end
    end
  end

  // Memory responder: checks each request, then grants and returns data.
  initial begin
    bus_t b; int n;
    dmem_gnt = 0;
    dmem_rvalid = 0;
    dmem_rdata = 0;
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        if (busq.size() == 0) begin
          chk("dmem_req_unexpected", {31'b0, dmem_req}, 32'd0);
          n = 0;
          while (dmem_req && n < TIMEOUT + 5) begin
            @(negedge clk);
            n++;
          end
        end else begin
          b = busq.pop_front();
          chk("dmem_addr", dmem_addr, b.addr);
          chk("dmem_be", {28'b0, dmem_be}, {28'b0, b.be});
          chk("dmem_we", {31'b0, dmem_we}, {31'b0, !b.load});
          if (!b.load) chk("dmem_wdata", dmem_wdata, b.wdata);
          if (b.g >= TIMEOUT) begin
            n = 0;
            while (dmem_req && n < TIMEOUT + 5) begin
              @(negedge clk);
              n++;
            end
          end else begin
            repeat (b.g) @(negedge clk);
            dmem_gnt = 1;
            @(negedge clk);
            dmem_gnt = 0;
            if (b.load && b.r > 0) begin
              repeat (b.r - 1) @(negedge clk);
              dmem_rvalid = 1;
              dmem_rdata  = b.rdata;
              @(negedge clk);
              dmem_rvalid = 0;
              dmem_rdata  = $urandom;
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ld, st, hold, prev_hold;
    logic [2:0] f3;
    logic [31:0] a;
    int g, r, k;
    rst = 0;
    req_valid = 0;
    is_load = 0;
    is_store = 0;
    funct3 = 0;
    addr = 0;
    store_data = 0;
    rd_addr = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_dmem", {dmem_req, dmem_we, dmem_be, 26'b0}, 32'd0);
    chk("rst_dmem_addr", dmem_addr | dmem_wdata, 32'd0);
    rst = 1;

    issue(1, 0, 3'b010, 32'h100, 0, 5'd3, 0, 1, 32'hDEADBEEF, 0, 0);
    issue(1, 0, 3'b000, 32'h103, 0, 5'd4, 0, 1, 32'h80000000, 0, 0);
    issue(1, 0, 3'b100, 32'h103, 0, 5'd5, 0, 1, 32'h80000000, 0, 0);
    issue(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 5'd6, 0, 0, 0, 0, 0);
    issue(1, 0, 3'b010, 32'h101, 0, 5'd7, 0, 1, 0, 0, 0);
    issue(1, 0, 3'b011, 32'h104, 0, 5'd8, 0, 1, 0, 0, 0);
    issue(1, 0, 3'b010, 32'h400, 0, 5'd9, TIMEOUT, 1, 0, 0, 0);
    issue(1, 0, 3'b001, 32'h402, 0, 5'd10, 1, 0, 0, 0, 0);

    // Reset while WAITing; the late rvalid must not produce a response.
    issue(1, 0, 3'b010, 32'h300, 0, 5'd11, 0, 40, 32'h12345678, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    expq.delete(expq.size() - 1);
    @(negedge clk);
    rst = 1;
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    repeat (60) @(negedge clk);

    issue(1, 0, 3'b010, 32'h500, 0, 5'd12, 0, 1, 32'hCAFEF00D, 1, 0);
    issue(0, 1, 3'b000, 32'h501, 32'h000000A5, 5'd13, 0, 0, 0, 1, 1);
    issue(1, 0, 3'b010, 32'h502, 0, 5'd14, 0, 1, 0, 1, 1);
    issue(1, 0, 3'b101, 32'h506, 0, 5'd15, 2, 3, 32'h9ABC0000, 0, 1);

    prev_hold = 0;
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 19));
      if (k == 0) begin
        ld = $urandom_range(0, 1);
        st = !ld || ($urandom_range(0, 3) == 0);
        f3 = ld ? (($urandom_range(0, 2) == 0) ? 3'b011 :
                   3'(6 + $urandom_range(0, 1)))
                : 3'(3 + $urandom_range(0, 4));
      end else begin
        ld = $urandom_range(0, 1);
        st = !ld;
        if (ld) begin
          k = int'($urandom_range(0, 4));
          f3 = (k < 3) ? 3'(k) : 3'(k + 1);
        end else begin
          f3 = 3'($urandom_range(0, 2));
        end
      end
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      g = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 5));
      r = int'($urandom_range(1, 4));
      hold = (i < 299) && ($urandom_range(0, 2) == 0);
      issue(ld, st, f3, a, $urandom, 5'($urandom), g, r, $urandom,
            hold, prev_hold);
      prev_hold = hold;
    end

    k = 0;
    while ((expq.size() != 0 || busq.size() != 0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_exp", expq.size(), 32'd0);
    chk("drain_bus", busq.size(), 32'd0);
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
